// File: rtl/rf_wr_arbiter_if.sv
// Register-file write-side bundle: WB write, MDU result handshake, hazard
// scoreboard lookups and the merged RF write bus.
interface rf_wr_arbiter_if #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 5,
   parameter int unsigned DW    = 32
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          wb_wr;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic          md_valid;
   logic [AW-1:0] md_addr;
   logic [DW-1:0] md_data;
   logic          md_ready;
   logic [AW-1:0] RsAddr;
   logic [AW-1:0] RtAddr;
   logic          RsPend;
   logic          RtPend;
   logic          RegWr;
   logic [AW-1:0] WrAddr;
   logic [DW-1:0] WrData;
   logic [CW-1:0] count;

   modport master (
      output wb_wr, wb_addr, wb_data, md_valid, md_addr, md_data, RsAddr, RtAddr,
      input  md_ready, RsPend, RtPend, RegWr, WrAddr, WrData, count
   );

   modport slave (
      input  wb_wr, wb_addr, wb_data, md_valid, md_addr, md_data, RsAddr, RtAddr,
      output md_ready, RsPend, RtPend, RegWr, WrAddr, WrData, count
   );
endinterface

// File: rtl/rf_wr_arbiter.sv
// RF write-port arbiter: WB writes pass through, MDU results queue in a FIFO with
// per-entry live bits (WAW squash) and drain on WB-idle cycles.
module rf_wr_arbiter #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 5,
   parameter int unsigned DW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   rf_wr_arbiter_if.slave bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [AW-1:0]    r_addr [DEPTH];
   logic [DW-1:0]    r_data [DEPTH];
   logic [DEPTH-1:0] r_live;
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             r_md_ready;

   logic             w_wb_act;
   logic             w_nempty;
   logic             w_head_live;
   logic             w_drain;
   logic             w_pop;
   logic             w_push;
   logic [CW-1:0]    w_count_d;
   logic [DEPTH-1:0] w_live_d;
   logic             w_rs_hit;
   logic             w_rt_hit;

   assign w_wb_act    = bus.wb_wr && (bus.wb_addr != '0);
   assign w_nempty    = (r_count != '0);
   assign w_head_live = r_live[r_rptr];
   assign w_drain     = w_nempty && w_head_live && !w_wb_act;
   // A squashed head never needs the write port, so it retires even under WB traffic.
   assign w_pop       = w_nempty && (!w_head_live || !w_wb_act);
   assign w_push      = bus.md_valid && r_md_ready && (bus.md_addr != '0);

   always_comb begin
      w_count_d = r_count;
      if (w_push && !w_pop) begin
         w_count_d = r_count + CW'(1);
      end else if (!w_push && w_pop) begin
         w_count_d = r_count - CW'(1);
      end
   end

   always_comb begin
      w_live_d = r_live;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_wb_act && (r_addr[i] == bus.wb_addr)) begin
            w_live_d[i] = 1'b0;
         end
      end
      if (w_pop) begin
         w_live_d[r_rptr] = 1'b0;
      end
      // A same-edge MDU enqueue is newer than the WB write, so it stays live.
      if (w_push) begin
         w_live_d[r_wptr] = 1'b1;
      end
   end

   always_comb begin
      w_rs_hit = 1'b0;
      w_rt_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_live[i] && (r_addr[i] == bus.RsAddr)) w_rs_hit = 1'b1;
         if (r_live[i] && (r_addr[i] == bus.RtAddr)) w_rt_hit = 1'b1;
      end
   end

   assign bus.RsPend = w_rs_hit && (bus.RsAddr != '0);
   assign bus.RtPend = w_rt_hit && (bus.RtAddr != '0);

   always_comb begin
      bus.RegWr  = 1'b0;
      bus.WrAddr = '0;
      bus.WrData = '0;
      if (w_wb_act) begin
         bus.RegWr  = 1'b1;
         bus.WrAddr = bus.wb_addr;
         bus.WrData = bus.wb_data;
      end else if (w_drain) begin
         bus.RegWr  = 1'b1;
         bus.WrAddr = r_addr[r_rptr];
         bus.WrData = r_data[r_rptr];
      end
   end

   assign bus.md_ready = r_md_ready;
   assign bus.count    = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
         end
         r_live     <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_md_ready <= 1'b0;
      end else begin
         r_live     <= w_live_d;
         r_count    <= w_count_d;
         r_md_ready <= (w_count_d < CW'(DEPTH));
         if (w_push) begin
            r_addr[r_wptr] <= bus.md_addr;
            r_data[r_wptr] <= bus.md_data;
            r_wptr         <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
      end
   end
endmodule
